keypad_scan: RTL and testbench

Scans a 4×4 active-low key matrix one row at a time, debounces the result per full scan frame, and emits a one-cycle key event with a 4-bit key code. Keeps a two-digit BCD entry buffer `q[7:0]` (tens in `q[7:4]`) that feeds the seven-segment display scanner directly. It is the input-side counterpart of the display scanner and sits between the keypad pins and game/control logic.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_debounce.sv | 151 +++++++++++++++
 rtl/keypad_scan.sv | 119 +++++++++++
 tb/tb_keypad_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// State, frame-result and key-code definitions used by keypad_scan and keypad_debounce.
package keypad_pkg;

    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] KEY_CLEAR = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_EMPTY,
        FR_SINGLE,
        FR_MULTI
    } frame_t;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level press/release debouncer for the keypad scanner.
// Optional auto-repeat while held is enabled with KEYPAD_REPEAT_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_stb,
    input  frame_t            frame_res,
    input  logic [CODE_W-1:0] frame_code,
    output logic              accept,
    output logic [CODE_W-1:0] accept_code,
    output logic              held
);

    localparam logic [4:0] DEB_N = DEBOUNCE[4:0];

    if (DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_debounce: parameter out of range");
    end

    kp_state_t         state;
    logic [4:0]        cnt;
    logic [CODE_W-1:0] cand;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] RDLY  = REPEAT_DELAY[15:0];
    localparam logic [15:0] RRATE = REPEAT_RATE[15:0];
    logic [15:0] rep_cnt;
    logic        rep_first;
    logic [15:0] rep_target;
    assign rep_target = rep_first ? RDLY : RRATE;
`endif

    // Accept decision is combinational so key_valid, key_code and q all land on the strobe edge.
    always_comb begin
        accept      = 1'b0;
        accept_code = cand;
        if (frame_stb) begin
            case (state)
                ST_IDLE: begin
                    if (frame_res == FR_SINGLE && DEB_N == 5'd1) begin
                        accept      = 1'b1;
                        accept_code = frame_code;
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_res == FR_SINGLE && frame_code == cand && cnt + 5'd1 == DEB_N)
                        accept = 1'b1;
                end
`ifdef KEYPAD_REPEAT_EN
                ST_HELD: begin
                    if (frame_res != FR_EMPTY && rep_cnt + 16'd1 == rep_target)
                        accept = 1'b1;
                end
`endif
                default: accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
            held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else if (frame_stb) begin
            case (state)
                ST_IDLE: begin
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
`endif
                    if (frame_res == FR_SINGLE) begin
                        cand <= frame_code;
                        cnt  <= 5'd1;
                        if (accept) begin
                            state <= ST_HELD;
                            held  <= 1'b1;
                        end else begin
                            state <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_res == FR_SINGLE) begin
                        if (frame_code == cand) begin
                            if (accept) begin
                                state <= ST_HELD;
                                held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end else begin
                            cand <= frame_code;
                            cnt  <= 5'd1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (frame_res == FR_EMPTY) begin
                        cnt <= 5'd1;
                        if (DEB_N == 5'd1) begin
                            state <= ST_IDLE;
                            held  <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (accept) begin
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 16'd1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (frame_res == FR_EMPTY) begin
                        if (cnt + 5'd1 == DEB_N) begin
                            state <= ST_IDLE;
                            held  <= 1'b0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end else begin
                        state <= ST_HELD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with per-frame debounce and a two-digit BCD entry buffer.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        col_n,
    output logic [3:0]        row_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic [7:0]        q
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("keypad_scan: SCAN_DIV must be at least 4");
    end

    logic [3:0]        col_s1, col_s2;
    logic [DIV_W-1:0]  div;
    logic [1:0]        r;
    logic [1:0]        acc_cnt;
    logic [CODE_W-1:0] acc_code;

    logic              sample, frame_stb;
    logic [3:0]        row_low;
    logic [2:0]        row_hits, hit_sum;
    logic [1:0]        row_col, new_cnt;
    logic [CODE_W-1:0] new_code;
    frame_t            frame_res;
    logic              accept;
    logic [CODE_W-1:0] accept_code;

    assign row_n     = ~(4'b0001 << r);
    assign sample    = (div == DIV_LAST);
    assign frame_stb = sample && (r == 2'd3);
    assign row_low   = ~col_s2;

    // acc_cnt saturates at 2: anything beyond a single press is just MULTI.
    always_comb begin
        row_hits = '0;
        row_col  = '0;
        for (int c = 3; c >= 0; c--) begin
            if (row_low[c]) begin
                row_hits = row_hits + 3'd1;
                row_col  = c[1:0];
            end
        end
        hit_sum  = {1'b0, acc_cnt} + row_hits;
        new_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        new_code = (acc_cnt == 2'd0) ? {r, row_col} : acc_code;
        case (new_cnt)
            2'd0:    frame_res = FR_EMPTY;
            2'd1:    frame_res = FR_SINGLE;
            default: frame_res = FR_MULTI;
        endcase
    end

    keypad_debounce #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_stb   (frame_stb),
        .frame_res   (frame_res),
        .frame_code  (new_code),
        .accept      (accept),
        .accept_code (accept_code),
        .held        (key_held)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1    <= 4'hF;
            col_s2    <= 4'hF;
            div       <= '0;
            r         <= '0;
            acc_cnt   <= '0;
            acc_code  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            q         <= 8'h00;
        end else begin
            col_s1    <= col_n;
            col_s2    <= col_s1;
            div       <= sample ? '0 : div + 1'b1;
            key_valid <= accept;
            if (sample) begin
                r <= r + 2'd1;
                if (frame_stb) begin
                    acc_cnt  <= '0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= new_cnt;
                    acc_code <= new_code;
                end
            end
            if (accept) begin
                key_code <= accept_code;
                if (accept_code <= 4'd9)
                    q <= {q[3:0], accept_code};
                else if (accept_code == KEY_CLEAR)
                    q <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (one frame = 16 clocks).
// Key changes are applied just after a frame boundary so each frame sees a constant key set.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE     = 3;
    localparam int REPEAT_DELAY = 4;
    localparam int REPEAT_RATE  = 2;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] q;
    logic [15:0] keys;

    int vectors     = 0;
    int miscompares = 0;
    int nvalid      = 0;
    int v0;

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .q         (q)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                if (!row_n[rr] && keys[4*rr+c]) col_n[c] = 1'b0;
    end

    always @(negedge clk) if (key_valid) nvalid++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic tap(input int k, input logic [7:0] exp_q);
        keys = 16'(1) << k;
        frames(3);
        check("tap_valid", 32'(key_valid), 32'd1);
        check("tap_code", 32'(key_code), 32'(k));
        check("tap_q", 32'(q), 32'(exp_q));
        keys = '0;
        frames(3);
        check("tap_released", 32'(key_held), 32'd0);
    endtask

    initial begin
        keys = '0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_row_n", 32'(row_n), 32'b1110);
        check("rst_q", 32'(q), 32'h00);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        rst = 1'b0;

        repeat (SCAN_DIV) @(posedge clk); #1;
        check("row1", 32'(row_n), 32'b1101);
        repeat (SCAN_DIV) @(posedge clk); #1;
        check("row2", 32'(row_n), 32'b1011);
        repeat (SCAN_DIV) @(posedge clk); #1;
        check("row3", 32'(row_n), 32'b0111);
        repeat (SCAN_DIV) @(posedge clk); #1;
        check("row0_wrap", 32'(row_n), 32'b1110);

        // Single press of key 5 (row 1, col 1) for 5 frames.
        v0   = nvalid;
        keys = 16'(1) << 5;
        frames(2);
        check("single_early_valid", 32'(key_valid), 32'd0);
        check("single_early_held", 32'(key_held), 32'd0);
        frames(1);
        check("single_valid", 32'(key_valid), 32'd1);
        check("single_code", 32'(key_code), 32'd5);
        check("single_q", 32'(q), 32'h05);
        check("single_held", 32'(key_held), 32'd1);
        frames(2);
        keys = '0;
        frames(2);
        check("release_still_held", 32'(key_held), 32'd1);
        frames(1);
        check("release_done", 32'(key_held), 32'd0);
        check("single_event_count", 32'(nvalid - v0), 32'd1);

        // Bounce key 3 on/off each frame, then hold it.
        v0 = nvalid;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (16'(1) << 3) : 16'h0000;
            frames(1);
            check("bounce_no_valid", 32'(key_valid), 32'd0);
            check("bounce_not_held", 32'(key_held), 32'd0);
        end
        keys = 16'(1) << 3;
        frames(2);
        check("bounce_hold_early", 32'(key_valid), 32'd0);
        frames(1);
        check("bounce_hold_valid", 32'(key_valid), 32'd1);
        check("bounce_hold_code", 32'(key_code), 32'd3);
        check("bounce_hold_q", 32'(q), 32'h53);
        keys = '0;
        frames(3);
        check("bounce_event_count", 32'(nvalid - v0), 32'd1);

        // Digit entry, a non-digit key, then clear.
        tap(1, 8'h31);
        tap(2, 8'h12);
        tap(10, 8'h12);
        tap(12, 8'h00);

        // Two keys together never produce an event.
        v0   = nvalid;
        keys = (16'(1) << 0) | (16'(1) << 5);
        frames(10);
        check("ghost_no_event", 32'(nvalid - v0), 32'd0);
        check("ghost_not_held", 32'(key_held), 32'd0);
        keys = '0;
        frames(2);

`ifdef KEYPAD_REPEAT_EN
        keys = 16'(1) << 7;
        for (int i = 1; i <= 12; i++) begin
            frames(1);
            check("repeat_pulse", 32'(key_valid), 32'((i == 3) || (i == 7) || (i == 9) || (i == 11)));
        end
        check("repeat_q", 32'(q), 32'h77);
        keys = '0;
        frames(3);
        check("repeat_released", 32'(key_held), 32'd0);
`endif

        // Reset mid-frame after 2 debounce frames must discard the progress.
        keys = 16'(1) << 9;
        frames(2);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_row_n", 32'(row_n), 32'b1110);
        check("midrst_valid", 32'(key_valid), 32'd0);
        rst = 1'b0;
        frames(2);
        check("midrst_no_early", 32'(key_valid), 32'd0);
        frames(1);
        check("midrst_valid_after", 32'(key_valid), 32'd1);
        check("midrst_code", 32'(key_code), 32'd9);
        check("midrst_q", 32'(q), 32'h09);
        keys = '0;
        frames(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
